// File: rtl/window_scan_sequencer_if.sv
// Pixel handshake, frame control and window/strobe outputs of the
// window scan sequencer, bundled as one port.
interface window_scan_sequencer_if #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);

    logic             start_i;
    logic             abort_i;
    logic             pixel_valid_i;
    logic             ready_o;
    logic             count_en_o;
    logic [COL_W-1:0] col_o;
    logic [ROW_W-1:0] row_o;
    logic             window_valid_o;
    logic [COL_W-1:0] win_col_o;
    logic [ROW_W-1:0] win_row_o;
    logic             eol_o;
    logic             busy_o;
    logic             frame_done_o;

    // Source / controller side
    modport master (
        output start_i, abort_i, pixel_valid_i,
        input  ready_o, count_en_o, col_o, row_o, window_valid_o,
        input  win_col_o, win_row_o, eol_o, busy_o, frame_done_o
    );

    // Sequencer side
    modport slave (
        input  start_i, abort_i, pixel_valid_i,
        output ready_o, count_en_o, col_o, row_o, window_valid_o,
        output win_col_o, win_row_o, eol_o, busy_o, frame_done_o
    );
endinterface

// File: rtl/window_scan_sequencer.sv
// Frame sequencer for the KxK sliding-window path: gates the pixel stream,
// owns the shared column/row counters, strobes each complete window with its
// centre coordinates and ends the frame with a one-cycle done pulse.
module window_scan_sequencer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int K      = 7
) (
    input logic                   clk,
    input logic                   rst_n,
    window_scan_sequencer_if.slave bus
);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam int HALF  = (K - 1) / 2;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(K - 1);
    localparam logic [COL_W-1:0] COL_HALF = COL_W'(HALF);
    localparam logic [ROW_W-1:0] ROW_HALF = ROW_W'(HALF);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             win_valid_q, win_valid_d;
    logic [COL_W-1:0] win_col_q, win_col_d;
    logic [ROW_W-1:0] win_row_q, win_row_d;
    logic             eol_q, eol_d;
    logic             ready;
    logic             accept;

    assign ready  = (state_q == S_RUN);
    assign accept = ready & bus.pixel_valid_i;

    // Next state, counter advance and window/end-of-line strobe generation
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        win_valid_d = 1'b0;
        win_col_d   = win_col_q;
        win_row_d   = win_row_q;
        eol_d       = 1'b0;

        // An accept in the abort cycle still shifts the buffers but its
        // strobes are dropped, since the frame is being discarded.
        if (accept && !bus.abort_i) begin
            if ((row_q >= ROW_MIN) && (col_q >= COL_MIN)) begin
                win_valid_d = 1'b1;
                win_col_d   = col_q - COL_HALF;
                win_row_d   = row_q - ROW_HALF;
            end
            eol_d = (col_q == COL_LAST);
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_RUN: begin
                if (bus.abort_i) begin
                    state_d = S_IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end else if (accept) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = S_FINISH;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                col_d   = '0;
                row_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                col_d   = '0;
                row_d   = '0;
            end
        endcase
    end

    // State, counters and registered strobes; reset clears everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
            eol_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_col_q   <= win_col_d;
            win_row_q   <= win_row_d;
            eol_q       <= eol_d;
        end
    end

    assign bus.ready_o        = ready;
    assign bus.count_en_o     = accept;
    assign bus.col_o          = col_q;
    assign bus.row_o          = row_q;
    assign bus.window_valid_o = win_valid_q;
    assign bus.win_col_o      = win_col_q;
    assign bus.win_row_o      = win_row_q;
    assign bus.eol_o          = eol_q;
    assign bus.busy_o         = (state_q != S_IDLE);
    assign bus.frame_done_o   = (state_q == S_FINISH);
endmodule

// File: tb/tb_window_scan_sequencer.sv
// Bench for window_scan_sequencer: an 8x8 and a 7x7 instance (K=7) driven
// one at a time, checked every cycle against a pixel-count reference model.
module tb_window_scan_sequencer;
    localparam int K = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start, abort, pv;
    logic sel;

    window_scan_sequencer_if #(.WIDTH(8), .HEIGHT(8)) bus_a ();
    window_scan_sequencer_if #(.WIDTH(7), .HEIGHT(7)) bus_b ();

    window_scan_sequencer #(.WIDTH(8), .HEIGHT(8), .K(K)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );
    window_scan_sequencer #(.WIDTH(7), .HEIGHT(7), .K(K)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    assign bus_a.start_i       = start & ~sel;
    assign bus_a.abort_i       = abort & ~sel;
    assign bus_a.pixel_valid_i = pv & ~sel;
    assign bus_b.start_i       = start & sel;
    assign bus_b.abort_i       = abort & sel;
    assign bus_b.pixel_valid_i = pv & sel;

    int o_ready, o_cen, o_col, o_row, o_wv, o_wc, o_wr, o_eol, o_busy, o_done;
    always_comb begin
        o_ready = sel ? int'(bus_b.ready_o)        : int'(bus_a.ready_o);
        o_cen   = sel ? int'(bus_b.count_en_o)     : int'(bus_a.count_en_o);
        o_col   = sel ? int'(bus_b.col_o)          : int'(bus_a.col_o);
        o_row   = sel ? int'(bus_b.row_o)          : int'(bus_a.row_o);
        o_wv    = sel ? int'(bus_b.window_valid_o) : int'(bus_a.window_valid_o);
        o_wc    = sel ? int'(bus_b.win_col_o)      : int'(bus_a.win_col_o);
        o_wr    = sel ? int'(bus_b.win_row_o)      : int'(bus_a.win_row_o);
        o_eol   = sel ? int'(bus_b.eol_o)          : int'(bus_a.eol_o);
        o_busy  = sel ? int'(bus_b.busy_o)         : int'(bus_a.busy_o);
        o_done  = sel ? int'(bus_b.frame_done_o)   : int'(bus_a.frame_done_o);
    end

    int n_tests, n_fail;

    // Reference model: phase 0 idle, 1 run, 2 finish; m_n = pixels accepted
    int m_w, m_h, m_ph, m_n, m_wv, m_wr, m_wc, m_eol;

    // Observations gathered over a frame
    int win_q[$];
    int ref_q[$];
    int eol_cnt, done_seen, done_with_win, seen_ready;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_n = 0; m_wv = 0; m_wr = 0; m_wc = 0; m_eol = 0;
    endtask

    task automatic model_clock();
        int  r, c;
        bit  acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        r   = m_n / m_w;
        c   = m_n % m_w;
        acc = (m_ph == 1) && pv && !abort;
        m_wv = (acc && r >= K - 1 && c >= K - 1) ? 1 : 0;
        if (m_wv == 1) begin
            m_wr = r - (K - 1) / 2;
            m_wc = c - (K - 1) / 2;
        end
        m_eol = (acc && c == m_w - 1) ? 1 : 0;
        if (abort && m_ph != 0) begin
            m_ph = 0; m_n = 0;
        end else if (m_ph == 0) begin
            if (start) begin m_ph = 1; m_n = 0; end
        end else if (m_ph == 2) begin
            m_ph = 0;
        end else if (acc) begin
            m_n++;
            if (m_n == m_w * m_h) begin m_ph = 2; m_n = 0; end
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check, advance model
    task automatic step(input logic s, input logic a, input logic v);
        start = s; abort = a; pv = v;
        #1;
        chk("ready",      o_ready, (m_ph == 1) ? 1 : 0);
        chk("count_en",   o_cen,   (m_ph == 1 && v) ? 1 : 0);
        chk("col",        o_col,   m_n % m_w);
        chk("row",        o_row,   m_n / m_w);
        chk("win_valid",  o_wv,    m_wv);
        chk("win_col",    o_wc,    m_wc);
        chk("win_row",    o_wr,    m_wr);
        chk("eol",        o_eol,   m_eol);
        chk("busy",       o_busy,  (m_ph != 0) ? 1 : 0);
        chk("frame_done", o_done,  (m_ph == 2) ? 1 : 0);
        seen_ready = o_ready;
        if (o_wv != 0) win_q.push_back(o_wr * 100 + o_wc);
        if (o_eol != 0) eol_cnt++;
        if (o_done != 0) begin
            done_seen = 1;
            if (o_wv != 0) done_with_win = 1;
        end
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    // mode 0: continuous valid, 1: valid on even cycles only, 2: random gaps
    task automatic run_frame(input int mode, input bit start_in_finish, output int len);
        int v;
        int ready_first;
        win_q.delete();
        eol_cnt = 0; done_seen = 0; done_with_win = 0; ready_first = 0;
        step(1'b1, 1'b0, 1'b0);
        len = 0;
        for (int i = 1; i <= 4000; i++) begin
            if (mode == 0)      v = 1;
            else if (mode == 1) v = (i % 2 == 0) ? 1 : 0;
            else                v = ($urandom_range(0, 3) != 0) ? 1 : 0;
            step((start_in_finish && m_ph == 2) ? 1'b1 : 1'b0, 1'b0, v[0]);
            if (i == 1) ready_first = seen_ready;
            len = i;
            if (done_seen != 0) break;
        end
        chk("ready_after_start", ready_first, 1);
        if (done_seen == 0) chk("frame_timeout", 0, 1);
    endtask

    task automatic check_frame(input int w, input int h);
        int exp_q[$];
        for (int r = (K - 1) / 2; r <= h - 1 - (K - 1) / 2; r++)
            for (int c = (K - 1) / 2; c <= w - 1 - (K - 1) / 2; c++)
                exp_q.push_back(r * 100 + c);
        chk("win_count", win_q.size(), (h - K + 1) * (w - K + 1));
        for (int i = 0; i < exp_q.size(); i++)
            chk("win_centre", (i < win_q.size()) ? win_q[i] : -1, exp_q[i]);
        chk("eol_count", eol_cnt, h);
        chk("done_with_last_win", done_with_win, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, o_ready, 0);
        chk({tag, "_cen"},   o_cen,   0);
        chk({tag, "_col"},   o_col,   0);
        chk({tag, "_row"},   o_row,   0);
        chk({tag, "_wv"},    o_wv,    0);
        chk({tag, "_wcol"},  o_wc,    0);
        chk({tag, "_wrow"},  o_wr,    0);
        chk({tag, "_eol"},   o_eol,   0);
        chk({tag, "_busy"},  o_busy,  0);
        chk({tag, "_done"},  o_done,  0);
    endtask

    initial begin
        int len;
        n_tests = 0; n_fail = 0;
        sel = 1'b0; start = 1'b0; abort = 1'b0; pv = 1'b0; rst_n = 1'b0;
        m_w = 8; m_h = 8;
        model_reset();
        eol_cnt = 0; done_seen = 0; done_with_win = 0; seen_ready = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all_zero("reset");

        // Continuous frame: done 65 cycles after start, four centred windows
        run_frame(0, 1'b0, len);
        chk("len_continuous", len, 65);
        check_frame(8, 8);
        ref_q = win_q;

        // Back-to-back frame started in the first IDLE cycle
        run_frame(0, 1'b0, len);
        chk("len_b2b", len, 65);
        check_frame(8, 8);
        chk("b2b_size", win_q.size(), ref_q.size());
        for (int i = 0; i < ref_q.size() && i < win_q.size(); i++)
            chk("b2b_seq", win_q[i], ref_q[i]);

        // Valid on alternate cycles: 128 RUN cycles then FINISH
        run_frame(1, 1'b0, len);
        chk("len_alternate", len, 129);
        check_frame(8, 8);

        // Random gaps
        repeat (3) begin
            run_frame(2, 1'b0, len);
            check_frame(8, 8);
        end

        // start_i held during FINISH must not launch a frame
        run_frame(0, 1'b1, len);
        check_frame(8, 8);
        #1;
        chk("finish_start_dropped", o_busy, 0);
        step(1'b0, 1'b0, 1'b0);
        chk("finish_start_still_idle", o_busy, 0);

        // Abort on the accept of pixel (6,6)
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && m_n != 6 * 8 + 6; i++) step(1'b0, 1'b0, 1'b1);
        chk("abort_reached_66", m_n, 6 * 8 + 6);
        win_q.delete();
        done_seen = 0;
        step(1'b0, 1'b1, 1'b1);
        chk("abort_idle", o_busy, 0);
        chk("abort_no_strobe", o_wv, 0);
        chk("abort_col", o_col, 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("abort_no_done", done_seen, 0);
        chk("abort_win_cnt", win_q.size(), 0);
        run_frame(0, 1'b0, len);
        check_frame(8, 8);

        // start_i while busy is ignored; then reset mid-row
        step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("busy_start_col", o_col, 6);
        chk("busy_start_row", o_row, 0);
        repeat (5) step(1'b0, 1'b0, 1'b1);
        chk("pre_reset_row", o_row, 1);
        done_seen = 0;
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        #1;
        check_all_zero("midreset");
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("midreset_no_done", done_seen, 0);

        // Minimal 7x7 image: one window, coincident with frame_done
        rst_n = 1'b0;
        sel = 1'b1;
        m_w = 7; m_h = 7;
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        run_frame(0, 1'b0, len);
        chk("len_7x7", len, 50);
        check_frame(7, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
